// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for mem_port_arbiter (used with or without MEM_ARB_PERF_CNT_EN)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_perf_counters.sv
// rtl/mem_arb_perf_counters.sv - saturating activity counters, instantiated only under MEM_ARB_PERF_CNT_EN
module mem_arb_perf_counters
    import mem_arb_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ireq,
    input  logic         dreq,
    input  logic         ivalid,
    input  logic         dvalid,
    output logic [W-1:0] perf_ifetch,
    output logic [W-1:0] perf_data,
    output logic [W-1:0] perf_conflict
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + W'(1) : v;
    endfunction

    // A conflict cycle is one where both sides wait and neither is being served.
    logic conflict;
    assign conflict = ireq && dreq && !ivalid && !dvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ifetch   <= '0;
            perf_data     <= '0;
            perf_conflict <= '0;
        end else begin
            perf_ifetch   <= sat_inc(perf_ifetch, ivalid);
            perf_data     <= sat_inc(perf_data, dvalid);
            perf_conflict <= sat_inc(perf_conflict, conflict);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port memory; perf counters under MEM_ARB_PERF_CNT_EN
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          ivalid,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dvalid,
    output logic          stall_fetch,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [AW-1:0] perf_ifetch,
    output logic [AW-1:0] perf_data,
    output logic [AW-1:0] perf_conflict
`endif
);

    arb_state_t state;
    logic       last_grant;
    logic       in_resp;
    logic       i_elig;
    logic       d_elig;
    logic       grant_i;
    logic       grant_d;

    // In RESP the side just served still shows its old request, so it is masked.
    assign in_resp = (state == RESP);
    assign i_elig  = ireq && !(in_resp && (last_grant == GRANT_FETCH));
    assign d_elig  = dreq && !(in_resp && (last_grant == GRANT_DATA));
    assign grant_d = d_elig && (!i_elig || (last_grant == GRANT_FETCH));
    assign grant_i = i_elig && !grant_d;

    assign stall_fetch = ireq && !ivalid;
    assign stall_mem   = dreq && !dvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_FETCH;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            irdata     <= '0;
            drdata     <= '0;
            ivalid     <= 1'b0;
            dvalid     <= 1'b0;
        end else begin
            ivalid <= 1'b0;
            dvalid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (grant_d) begin
                        state      <= DBUSY;
                        last_grant <= GRANT_DATA;
                        mem_req    <= 1'b1;
                        mem_we     <= dwe;
                        mem_addr   <= daddr;
                        mem_wdata  <= dwdata;
                    end else if (grant_i) begin
                        state      <= IBUSY;
                        last_grant <= GRANT_FETCH;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= iaddr;
                    end else begin
                        state <= IDLE;
                    end
                end
                IBUSY: begin
                    if (mem_ready) begin
                        irdata  <= mem_rdata;
                        ivalid  <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                DBUSY: begin
                    if (mem_ready) begin
                        drdata  <= mem_rdata;
                        dvalid  <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    mem_arb_perf_counters #(.W(AW)) u_perf (
        .clk           (clk),
        .reset         (reset),
        .ireq          (ireq),
        .dreq          (dreq),
        .ivalid        (ivalid),
        .dvalid        (dvalid),
        .perf_ifetch   (perf_ifetch),
        .perf_data     (perf_data),
        .perf_conflict (perf_conflict)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (perf checks under MEM_ARB_PERF_CNT_EN)
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwe, mem_ready;
    logic [31:0] iaddr, daddr, dwdata, mem_rdata;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata;
    logic        ivalid, dvalid, stall_fetch, stall_mem, mem_req, mem_we;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_ifetch, perf_data, perf_conflict;
`endif

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq        (ireq),
        .iaddr       (iaddr),
        .irdata      (irdata),
        .ivalid      (ivalid),
        .dreq        (dreq),
        .dwe         (dwe),
        .daddr       (daddr),
        .dwdata      (dwdata),
        .drdata      (drdata),
        .dvalid      (dvalid),
        .stall_fetch (stall_fetch),
        .stall_mem   (stall_mem),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_ifetch   (perf_ifetch),
        .perf_data     (perf_data),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_item_t;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_c;
    } exp_t;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_c;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    logic [31:0] fq[$];
    dreq_item_t  dq[$];
    exp_t        exp_q[$];

    int errors = 0;
    int checks = 0;
    int wait_cycles = 0;
    bit tie_ready = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'hDEADBEFF ^ a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_f(input logic [31:0] a);
        exp_t e;
        fq.push_back(a);
        e.is_data = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = '0;
        e.rdata = mem_fn(a); e.wait_c = tie_ready ? 0 : wait_cycles;
        exp_q.push_back(e);
    endtask

    task automatic push_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
        dreq_item_t it;
        exp_t e;
        it.we = we; it.addr = a; it.wdata = wd;
        dq.push_back(it);
        e.is_data = 1'b1; e.we = we; e.addr = a; e.wdata = wd;
        e.rdata = mem_fn(a); e.wait_c = tie_ready ? 0 : wait_cycles;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input bit want_data, output int t);
        t = -1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (want_data ? dvalid : ivalid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now(want_data ? "timeout_dvalid" : "timeout_ivalid");
    endtask

    task automatic wait_any(output int t);
        t = -1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (ivalid || dvalid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("timeout_any_valid");
    endtask

    task automatic do_reset();
        @(negedge clk);
        fq.delete();
        dq.delete();
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // Fetch requester: holds ireq until its ivalid, then moves on to the next queued address.
    initial begin
        ireq = 1'b0;
        iaddr = '0;
        forever begin
            @(negedge clk);
            if (ireq && ivalid && fq.size() > 0) void'(fq.pop_front());
            if (fq.size() > 0) begin
                ireq = 1'b1;
                iaddr = fq[0];
            end else begin
                ireq = 1'b0;
            end
        end
    end

    initial begin
        dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
        forever begin
            @(negedge clk);
            if (dreq && dvalid && dq.size() > 0) void'(dq.pop_front());
            if (dq.size() > 0) begin
                dreq = 1'b1; dwe = dq[0].we; daddr = dq[0].addr; dwdata = dq[0].wdata;
            end else begin
                dreq = 1'b0; dwe = 1'b0;
            end
        end
    end

    // Memory model: completes after wait_cycles cycles of mem_req, or every cycle when tied ready.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (tie_ready) begin
                mem_ready = 1'b1;
                mem_rdata = mem_fn(mem_addr);
                cnt = 0;
            end else if (mem_req) begin
                if (cnt >= wait_cycles) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_fn(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'h0BAD_0BAD;
                end
                cnt++;
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Scoreboard monitor: checks each access start, bus stability, completion and stalls.
    initial begin : monitor
        exp_t        e;
        bit          prev_req;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        int          blen;
        prev_req = 1'b0; blen = 0; h_addr = '0; h_wdata = '0; h_we = 1'b0;
        forever begin
            tick();
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_access_start");
                    end else begin
                        e = exp_q[0];
                        chk("start_addr", 64'(mem_addr), 64'(e.addr));
                        chk("start_we", 64'(mem_we), 64'(e.we));
                        if (e.we) chk("start_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                    h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata; blen = 1;
                end else if (mem_req) begin
                    chk("hold_addr", 64'(mem_addr), 64'(h_addr));
                    chk("hold_we_wdata", 64'({mem_we, mem_wdata}), 64'({h_we, h_wdata}));
                    blen++;
                end
                if (ivalid && dvalid) begin
                    fail_now("both_valids_high");
                end else if (ivalid || dvalid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_valid");
                    end else begin
                        e = exp_q.pop_front();
                        chk("valid_side", 64'(dvalid), 64'(e.is_data));
                        chk("busy_len", 64'(blen), 64'(e.wait_c + 1));
                        if (!e.we) chk("rdata", 64'(dvalid ? drdata : irdata), 64'(e.rdata));
                    end
                end
                chk("stall_fetch", 64'(stall_fetch), 64'(ireq & ~ivalid));
                chk("stall_mem", 64'(stall_mem), 64'(dreq & ~dvalid));
                prev_req = mem_req;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        int          c0, t, td, ti, tprev;
        logic [31:0] last_i, last_d;
        bit          last_d_known;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,      2, 4, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,      5, 7, 32'hDEADBEBF};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234,   0, 2, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_03FF, 32'h0,      1, 3, 32'hDEADBD00};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,      0, 2, 32'h21524100};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("reset_mem_bus", 64'({mem_req, mem_we}), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("reset_rdata", {irdata, drdata}, 64'(0));
        chk("reset_valids", 64'({ivalid, dvalid, stall_fetch, stall_mem}), 64'(0));

        last_i = '0; last_d = '0; last_d_known = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cycles = vecs[i].wait_c;
            c0 = cyc;
            if (vecs[i].is_data) push_d(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            else push_f(vecs[i].addr);
            wait_valid(vecs[i].is_data, t);
            chk($sformatf("vec%0d_latency", i), 64'(t - c0), 64'(vecs[i].exp_lat));
            if (vecs[i].is_data) begin
                chk($sformatf("vec%0d_irdata_held", i), 64'(irdata), 64'(last_i));
                if (!vecs[i].we) begin
                    chk($sformatf("vec%0d_drdata", i), 64'(drdata), 64'(vecs[i].exp_rdata));
                    last_d = vecs[i].exp_rdata;
                    last_d_known = 1'b1;
                end else begin
                    last_d_known = 1'b0;
                end
            end else begin
                chk($sformatf("vec%0d_irdata", i), 64'(irdata), 64'(vecs[i].exp_rdata));
                if (last_d_known) chk($sformatf("vec%0d_drdata_held", i), 64'(drdata), 64'(last_d));
                last_i = vecs[i].exp_rdata;
            end
            repeat (2) tick();
        end

        // Simultaneous store and fetch right after reset: data first, fetch granted in RESP.
        do_reset();
        wait_cycles = 0;
        c0 = cyc;
        push_d(1'b1, 32'h20, 32'h1234);
        push_f(32'h4);
        wait_valid(1'b1, td);
        chk("simul_dvalid_latency", 64'(td - c0), 64'(2));
        wait_valid(1'b0, ti);
        chk("simul_ivalid_gap", 64'(ti - td), 64'(2));
        chk("simul_irdata", 64'(irdata), 64'(32'hDEADBEFB));
        repeat (2) tick();

        // Continuous contention with mem_ready tied high.
        do_reset();
        tie_ready = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            push_d(1'b0, 32'h100 + 32'(k), 32'h0);
            push_f(32'h200 + 32'(k));
        end
        tprev = c0;
        for (int k = 0; k < 10; k++) begin
            wait_any(t);
            chk($sformatf("contention_gap%0d", k), 64'(t - tprev), 64'(2));
            chk($sformatf("contention_side%0d", k), 64'(dvalid), 64'((k % 2) == 0));
            tprev = t;
        end
        repeat (3) tick();
        tie_ready = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_ifetch", 64'(perf_ifetch), 64'(5));
        chk("perf_data", 64'(perf_data), 64'(5));
        chk("perf_conflict", 64'(perf_conflict), 64'(10));
`endif
        repeat (2) tick();

        // Load with wait states; fetch arrives mid-access and waits for RESP.
        wait_cycles = 5;
        c0 = cyc;
        push_d(1'b0, 32'h40, 32'h0);
        repeat (2) tick();
        push_f(32'h8);
        wait_valid(1'b1, td);
        chk("ws_dvalid_latency", 64'(td - c0), 64'(7));
        chk("ws_drdata", 64'(drdata), 64'(32'hDEADBEBF));
        wait_valid(1'b0, ti);
        chk("ws_fetch_after_resp", 64'(ti - td), 64'(7));
        repeat (2) tick();

        // Reset during DBUSY abandons the access without a valid pulse.
        wait_cycles = 20;
        push_d(1'b0, 32'h60, 32'h0);
        repeat (3) tick();
        chk("midreset_busy", 64'(mem_req), 64'(1));
        @(negedge clk);
        fq.delete();
        dq.delete();
        exp_q.delete();
        reset = 1'b1;
        tick();
        chk("midreset_req_valid", 64'({mem_req, mem_we, ivalid, dvalid}), 64'(0));
        chk("midreset_addr_wdata", {mem_addr, mem_wdata}, 64'(0));
        chk("midreset_rdata", {irdata, drdata}, 64'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        wait_cycles = 1;
        c0 = cyc;
        push_f(32'h44);
        wait_valid(1'b0, t);
        chk("postreset_latency", 64'(t - c0), 64'(3));
        chk("postreset_irdata", 64'(irdata), 64'(32'hDEADBEBB));
        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
